// File: rtl/fifo_tx.sv
// fifo_tx - transmit-side N-char FIFO for an ECSS-E-ST-50-12C link.
//
// Buffers N-chars from the host and hands them to the TX encoder only while
// transmit credit is available. Each FCT reported by the local receiver adds
// FCT_CREDIT; each N-char read consumes one credit. An FCT that would push
// credit above MAX_CREDIT is refused and latches credit_error.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   wr_en        host write strobe, one entry per cycle while not full
//   data_in      host N-char (bit 8 = control flag, bits 7:0 = data)
//   rd_en        encoder read request, single-cycle pulse
//   fct_in       single-cycle pulse, one FCT decoded by the receiver
//   data_out     registered N-char to the encoder
//   data_valid   one-cycle pulse, data_out holds a freshly read N-char
//   f_full       FIFO holds 2**AWIDTH entries
//   f_empty      FIFO holds no entries
//   credit_ok    tx_credit is non-zero
//   tx_credit    current transmit credit, 0..MAX_CREDIT
//   credit_error sticky remote credit overflow flag
//   counter      FIFO occupancy, 0..2**AWIDTH
//
// Credit FSM:
//   state      | meaning
//   NO_CREDIT  | tx_credit == 0, reads are held off
//   HAS_CREDIT | 0 < tx_credit <= MAX_CREDIT, reads allowed
//   ERROR      | credit overflow seen; accounting continues until reset

module fifo_tx #(
    parameter int DWIDTH     = 9,
    parameter int AWIDTH     = 6,
    parameter int MAX_CREDIT = 56,
    parameter int FCT_CREDIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              rd_en,
    input  logic              fct_in,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_valid,
    output logic              f_full,
    output logic              f_empty,
    output logic              credit_ok,
    output logic [AWIDTH-1:0] tx_credit,
    output logic              credit_error,
    output logic [AWIDTH:0]   counter
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0] MAX_C   = (AWIDTH + 1)'(MAX_CREDIT);
    localparam logic [AWIDTH:0] FCT_C   = (AWIDTH + 1)'(FCT_CREDIT);

    typedef enum logic [1:0] {
        NO_CREDIT  = 2'd0,
        HAS_CREDIT = 2'd1,
        ERROR      = 2'd2
    } credit_state_t;

    credit_state_t     state;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;

    logic              wr_acc;
    logic              rd_acc;
    logic [AWIDTH:0]   counter_next;
    logic [AWIDTH:0]   cred_base;
    logic [AWIDTH:0]   cred_sum;
    logic              fct_ovf;
    logic [AWIDTH:0]   credit_next;

    always_comb begin
        wr_acc = wr_en && !f_full;
        rd_acc = rd_en && !f_empty && credit_ok;

        counter_next = counter;
        if (wr_acc && !rd_acc)
            counter_next = counter + (AWIDTH + 1)'(1);
        else if (rd_acc && !wr_acc)
            counter_next = counter - (AWIDTH + 1)'(1);

        // A same-cycle read is taken off first, so the overflow test sees
        // the credit that will really be outstanding after this edge.
        cred_base   = {1'b0, tx_credit} - {{AWIDTH{1'b0}}, rd_acc};
        cred_sum    = cred_base + FCT_C;
        fct_ovf     = fct_in && (cred_sum > MAX_C);
        credit_next = cred_base;
        if (fct_in && !fct_ovf)
            credit_next = cred_sum;
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (wr_acc)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= NO_CREDIT;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            counter      <= '0;
            f_full       <= 1'b0;
            f_empty      <= 1'b1;
            data_out     <= '0;
            data_valid   <= 1'b0;
            tx_credit    <= '0;
            credit_ok    <= 1'b0;
            credit_error <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + AWIDTH'(1);

            data_valid <= rd_acc;
            if (rd_acc) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AWIDTH'(1);
            end

            counter <= counter_next;
            f_full  <= (counter_next == DEPTH_C);
            f_empty <= (counter_next == '0);

            tx_credit    <= credit_next[AWIDTH-1:0];
            credit_ok    <= (credit_next != '0);
            credit_error <= (state == ERROR) || fct_ovf;

            if ((state == ERROR) || fct_ovf)
                state <= ERROR;
            else if (credit_next == '0)
                state <= NO_CREDIT;
            else
                state <= HAS_CREDIT;
        end
    end

endmodule

// File: tb/tb_fifo_tx.sv
module tb_fifo_tx;

    logic       clock;
    logic       reset;
    logic       wr_en;
    logic [8:0] data_in;
    logic       rd_en;
    logic       fct_in;
    logic [8:0] data_out;
    logic       data_valid;
    logic       f_full;
    logic       f_empty;
    logic       credit_ok;
    logic [5:0] tx_credit;
    logic       credit_error;
    logic [6:0] counter;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q [$];   // scoreboard: N-chars expected on data_out
    logic [8:0] mdl_q [$];   // model of FIFO contents

    fifo_tx dut (
        .clock        (clock),
        .reset        (reset),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .fct_in       (fct_in),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .f_full       (f_full),
        .f_empty      (f_empty),
        .credit_ok    (credit_ok),
        .tx_credit    (tx_credit),
        .credit_error (credit_error),
        .counter      (counter)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every data_valid pulse must match the next scoreboard entry.
    always @(negedge clock) begin
        if (reset && data_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: actual=0x%0h required=no output", data_out);
            end else begin
                check("data_out", int'(data_out), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic wr(input logic [8:0] d, input bit acc);
        wr_en = 1'b1; data_in = d;
        if (acc) mdl_q.push_back(d);
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic rd(input bit acc, input bit fct);
        rd_en = 1'b1; fct_in = fct;
        if (acc) exp_q.push_back(mdl_q.pop_front());
        @(negedge clock);
        rd_en = 1'b0; fct_in = 1'b0;
    endtask

    task automatic fct();
        fct_in = 1'b1;
        @(negedge clock);
        fct_in = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_counter"},   int'(counter),      0);
        check({tag, "_f_empty"},   int'(f_empty),      1);
        check({tag, "_f_full"},    int'(f_full),       0);
        check({tag, "_tx_credit"}, int'(tx_credit),    0);
        check({tag, "_credit_ok"}, int'(credit_ok),    0);
        check({tag, "_cred_err"},  int'(credit_error), 0);
        check({tag, "_valid"},     int'(data_valid),   0);
        check({tag, "_data_out"},  int'(data_out),     0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_q.delete();
        mdl_q.delete();
        #1;
        check_reset_vals("rst");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; data_in = '0; rd_en = 1'b0; fct_in = 1'b0;
        @(negedge clock);
        do_reset();

        // No credit: reads refused
        wr(9'h041, 1); wr(9'h142, 1); wr(9'h043, 1);
        rd(0, 0);
        check("nocred_valid",  int'(data_valid), 0);
        check("nocred_credit", int'(tx_credit),  0);
        check("nocred_count",  int'(counter),    3);
        check("nocred_ok",     int'(credit_ok),  0);

        // One FCT, three reads
        fct();
        check("fct1_credit", int'(tx_credit), 8);
        check("fct1_ok",     int'(credit_ok), 1);
        for (int i = 0; i < 3; i++) rd(1, 0);
        check("rd3_credit", int'(tx_credit), 5);
        check("rd3_count",  int'(counter),   0);
        check("rd3_empty",  int'(f_empty),   1);

        // Fill to full across pointer wrap (pointers start at 3)
        for (int i = 0; i < 64; i++) wr(9'(9'h100 + i), 1);
        check("full_flag",  int'(f_full),  1);
        check("full_count", int'(counter), 64);
        check("full_empty", int'(f_empty), 0);
        wr(9'h0AA, 0);
        check("full_ignore_count", int'(counter), 64);
        check("full_ignore_flag",  int'(f_full),  1);

        fct();
        check("fill_credit", int'(tx_credit), 13);
        for (int i = 0; i < 8; i++) rd(1, 0);
        check("rd8_count",  int'(counter),   56);
        check("rd8_credit", int'(tx_credit), 5);
        check("rd8_full",   int'(f_full),    0);

        // Drain credit, then a refused read
        for (int i = 0; i < 5; i++) rd(1, 0);
        check("drain_credit", int'(tx_credit), 0);
        check("drain_ok",     int'(credit_ok), 0);
        rd(0, 0);
        check("refused_count", int'(counter),    51);
        check("refused_valid", int'(data_valid), 0);

        // Credit up to the limit, then overflow
        for (int i = 0; i < 7; i++) fct();
        check("max_credit", int'(tx_credit),    56);
        check("max_err",    int'(credit_error), 0);
        fct();
        check("ovf_credit", int'(tx_credit),    56);
        check("ovf_err",    int'(credit_error), 1);
        rd(1, 0);
        check("err_sticky",     int'(credit_error), 1);
        check("err_rd_credit",  int'(tx_credit),    55);

        // Simultaneous FCT and read at the boundary
        do_reset();
        for (int i = 0; i < 20; i++) wr(9'(9'h020 + i), 1);
        for (int i = 0; i < 7; i++) fct();
        for (int i = 0; i < 7; i++) rd(1, 0);
        check("c49_credit", int'(tx_credit), 49);
        check("c49_count",  int'(counter),   13);
        rd(1, 1);
        check("c49_fct_credit", int'(tx_credit),    56);
        check("c49_fct_err",    int'(credit_error), 0);
        check("c49_fct_count",  int'(counter),      12);
        for (int i = 0; i < 6; i++) rd(1, 0);
        check("c50_credit", int'(tx_credit), 50);
        rd(1, 1);
        check("c50_fct_credit", int'(tx_credit),    49);
        check("c50_fct_err",    int'(credit_error), 1);
        check("c50_fct_count",  int'(counter),      5);

        // Asynchronous reset mid-operation
        do_reset();
        for (int i = 0; i < 10; i++) wr(9'(9'h0C0 + i), 1);
        fct(); fct();
        check("pre_rst_count",  int'(counter),   10);
        check("pre_rst_credit", int'(tx_credit), 16);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("async");
        mdl_q.delete();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);

        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
